vp_fb_writer: RTL
=================

VP_FB_WRITER -- requirements
Module: vp_fb_writer

Interface
REQ-001 Parameter DW, default 12: pixel data width.
REQ-002 Parameter RL, default 640: pixels per row.
REQ-003 Parameter RN, default 480: rows per frame.
REQ-004 Parameter AW, default 19: frame-buffer address width; RL*RN SHALL be at most 2**AW.
REQ-005 Parameter TH, default 12'h200: binarization threshold, used only with FB_THRESHOLD_EN.
REQ-006 i_clk  input  1  clock; i_rstn  input  1  reset, synchronous, active-low.
REQ-007 o_data_ready  output  1  single-cycle pop strobe to the upstream video-processing output FIFO.
REQ-008 i_data_valid  input  1  upstream FIFO holds data, not almost-empty.
REQ-009 i_data  input  DW  upstream FIFO read data, valid the cycle after the pop strobe.
REQ-010 i_sof  input  1  start-of-frame: restart the address counter.
REQ-011 o_wr_en  output  1  frame-buffer write enable.
REQ-012 o_wr_addr  output  AW  frame-buffer write address.
REQ-013 o_wr_data  output  DW  frame-buffer write data.
REQ-014 o_frame_done  output  1  one-cycle pulse on the write of the last pixel of a frame.
REQ-015 o_busy  output  1  high when the state is not IDLE or o_wr_en is high.

Function
REQ-016 The block SHALL implement three states: IDLE, POP and CAPT.
REQ-017 IDLE: when i_data_valid=1, go to POP with o_data_ready registered high; otherwise stay in IDLE with o_data_ready=0.
REQ-018 POP (cycle n, o_data_ready=1): drop o_data_ready to 0 and go to CAPT.
REQ-019 CAPT (cycle n+1): register i_data into o_wr_data, set o_wr_en=1 for cycle n+2 only, and go to IDLE.
REQ-020 o_data_ready SHALL never be high on two consecutive cycles and SHALL never rise while i_data_valid=0 in IDLE.
REQ-021 Exactly one o_wr_en cycle SHALL follow each o_data_ready pulse, with no lost or duplicated pixels; maximum throughput is one pixel per 3 cycles.
REQ-022 During an o_wr_en cycle, o_wr_addr SHALL hold the current pixel index; the counter advances at the end of that cycle.
REQ-023 At the write with address RL*RN-1, o_frame_done=1 in the same cycle and the counter wraps to 0.
REQ-024 i_sof=1 SHALL load the counter with 0 at the next edge, with priority over increment; a write coincident with i_sof still uses the pre-sof address.
REQ-025 i_sof does not alter state, o_data_ready or a pending capture.
REQ-026 i_data_valid falling while in POP or CAPT does not abort the transfer; the popped word is still written.
REQ-027 o_frame_done SHALL be asserted only on a write to address RL*RN-1, never on an i_sof alone.

Reset
REQ-028 While i_rstn=0 at a clock edge: state IDLE, counter 0, and o_data_ready, o_wr_en, o_wr_addr, o_wr_data, o_frame_done and o_busy all 0.
REQ-029 Reset asserted in POP or CAPT SHALL discard the in-flight pixel with no write issued.
REQ-030 The first pop after reset release SHALL occur no earlier than the first edge at which i_data_valid=1.

Configuration
REQ-031 With macro FB_THRESHOLD_EN defined, the captured o_wr_data SHALL be all ones if i_data>=TH, else 0.
REQ-032 Without FB_THRESHOLD_EN, o_wr_data SHALL equal i_data unchanged, and TH has no effect.
REQ-033 Latency and handshake timing SHALL be identical with and without FB_THRESHOLD_EN.

Verification
REQ-034 i_data_valid held 1 with i_data=12'h0A5 after the pop -> o_data_ready pulses every 3 cycles; o_wr_en high 2 cycles after each pulse with o_wr_data=12'h0A5 and addresses 0,1,2,...
REQ-035 Stream RL*RN=307200 pixels -> o_frame_done single pulse with o_wr_addr=307199; next write at address 0.
REQ-036 i_sof=1 during the write at address 1000 -> that write lands at 1000, next write at 0, no o_frame_done.
REQ-037 Drop i_data_valid to 0 in the POP cycle -> write still issued; no further o_data_ready until i_data_valid returns to 1.
REQ-038 i_rstn=0 in the CAPT cycle -> no o_wr_en; all outputs 0; next write after reset at address 0.
REQ-039 With FB_THRESHOLD_EN and TH=12'h200: inputs 12'h1FF and 12'h200 -> writes 12'h000 and 12'hFFF.

Source files
------------

// File: rtl/vp_fb_writer.sv
// Frame-buffer writer: pops pixels from the upstream FIFO and writes them at sequential addresses.
// Latency: pop strobe in cycle n, capture in n+1, write in n+2; at most one pixel per 3 cycles.
// Backpressure: pops only while i_data_valid=1 in IDLE; a started transfer always completes unless reset.
//
// Optional build macro FB_THRESHOLD_EN: binarize captured data against TH (all ones if >= TH, else 0).
//
// Ports:
//   i_clk, i_rstn     clock, synchronous active-low reset
//   o_data_ready      single-cycle pop strobe to the upstream FIFO
//   i_data_valid      upstream FIFO holds data
//   i_data            upstream read data, valid the cycle after the pop strobe
//   i_sof             start-of-frame, restarts the address counter
//   o_wr_en/o_wr_addr/o_wr_data  frame-buffer write port
//   o_frame_done      pulse on the write of the last pixel of a frame
//   o_busy            transfer in flight or write in progress
module vp_fb_writer #(
    parameter int              DW = 12,
    parameter int              RL = 640,
    parameter int              RN = 480,
    parameter int              AW = 19,
    parameter logic [DW-1:0]   TH = DW'(12'h200)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    output logic          o_data_ready,
    input  logic          i_data_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_sof,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_frame_done,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2
    } state_t;

    localparam int            NPIX = RL * RN;
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic [DW-1:0] cap_dat;

    // Counter is the write address itself: it holds through the write
    // cycle and moves afterwards. Start-of-frame wins over the increment.
    always_comb begin
        cnt_nxt = cnt;
        if (i_sof) begin
            cnt_nxt = '0;
        end else if (o_wr_en) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + AW'(1);
        end
    end

`ifdef FB_THRESHOLD_EN
    assign cap_dat = (i_data >= TH) ? {DW{1'b1}} : {DW{1'b0}};
`else
    logic unused_th;
    assign unused_th = ^TH;
    assign cap_dat   = i_data;
`endif

    assign o_wr_addr = cnt;
    assign o_busy    = (state != IDLE) || o_wr_en;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            o_data_ready <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            o_data_ready <= 1'b0;
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_data_valid) begin
                        state        <= POP;
                        o_data_ready <= 1'b1;
                    end
                end
                POP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    o_wr_data    <= cap_dat;
                    o_wr_en      <= 1'b1;
                    // The write lands at the counter value after this edge,
                    // which already accounts for a start-of-frame now.
                    o_frame_done <= (cnt_nxt == LAST);
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
